// File: rtl/uart_rx_io_pkg.sv
// rtl/uart_rx_io_pkg.sv - shared register offsets, status bit indices and receive FSM states
package uart_rx_io_pkg;

    localparam logic [31:0] UART_RX_STATUS_OFFSET = 32'd0;
    localparam logic [31:0] UART_RX_DATA_OFFSET   = 32'd4;

    localparam int UART_RX_STAT_NOT_EMPTY  = 0;
    localparam int UART_RX_STAT_OVERRUN    = 1;
    localparam int UART_RX_STAT_FRAME_ERR  = 2;
    localparam int UART_RX_STAT_PARITY_ERR = 3;

    typedef enum logic [2:0] {
        UART_RX_IDLE,
        UART_RX_START,
        UART_RX_DATA,
        UART_RX_PARITY,
        UART_RX_STOP
    } uart_rx_state_t;

    // Assemble the status register word from its individual flags.
    function automatic logic [31:0] uart_rx_status_word(
        input logic not_empty,
        input logic overrun,
        input logic frame_err,
        input logic parity_err
    );
        logic [31:0] w;
        w = 32'd0;
        w[UART_RX_STAT_NOT_EMPTY]  = not_empty;
        w[UART_RX_STAT_OVERRUN]    = overrun;
        w[UART_RX_STAT_FRAME_ERR]  = frame_err;
        w[UART_RX_STAT_PARITY_ERR] = parity_err;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - synchronizer, receive FSM, bit counter and shift register (8E1 when UART_RX_PARITY_EN is defined)
module uart_rx_deserializer
    import uart_rx_io_pkg::*;
#(
    parameter int BAUD_DIVIDE = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error,
    output logic       parity_error
);

    localparam int CW = $clog2(BAUD_DIVIDE);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(BAUD_DIVIDE - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(BAUD_DIVIDE / 2 - 1);

    logic           r_sync1;
    logic           r_sync2;
    logic           w_rx;

    uart_rx_state_t r_state;
    uart_rx_state_t w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [2:0]     r_bit_idx;
    logic [2:0]     w_bit_idx_nxt;
    logic [7:0]     r_shift;
    logic [7:0]     w_shift_nxt;
    logic           r_stop_wait;
    logic           w_stop_wait_nxt;
    logic           r_byte_valid;
    logic           w_byte_valid_nxt;
    logic           r_frame_error;
    logic           w_frame_error_nxt;
    logic           r_parity_error;
    logic           w_parity_error_nxt;
    logic           w_expire;
    logic           w_par_bad;

`ifdef UART_RX_PARITY_EN
    logic           r_par_err;
    logic           w_par_err_nxt;
    assign w_par_bad = r_par_err;
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_rx     = r_sync2;
    assign w_expire = (r_cnt == '0);

    // Two-flop synchronizer; idle-high reset so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    // FSM, counter, shift register and output pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= UART_RX_IDLE;
            r_cnt          <= '0;
            r_bit_idx      <= 3'd0;
            r_shift        <= 8'd0;
            r_stop_wait    <= 1'b0;
            r_byte_valid   <= 1'b0;
            r_frame_error  <= 1'b0;
            r_parity_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err      <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_bit_idx      <= w_bit_idx_nxt;
            r_shift        <= w_shift_nxt;
            r_stop_wait    <= w_stop_wait_nxt;
            r_byte_valid   <= w_byte_valid_nxt;
            r_frame_error  <= w_frame_error_nxt;
            r_parity_error <= w_parity_error_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_err      <= w_par_err_nxt;
`endif
        end
    end

    // Next-state logic: counter runs down every cycle, work happens at expiry.
    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = w_expire ? r_cnt : r_cnt - CW'(1);
        w_bit_idx_nxt      = r_bit_idx;
        w_shift_nxt        = r_shift;
        w_stop_wait_nxt    = r_stop_wait;
        w_byte_valid_nxt   = 1'b0;
        w_frame_error_nxt  = 1'b0;
        w_parity_error_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_err_nxt      = r_par_err;
`endif
        case (r_state)
            UART_RX_IDLE: begin
                if (!w_rx) begin
                    w_state_nxt = UART_RX_START;
                    w_cnt_nxt   = HALF_RELOAD;
                end
            end
            UART_RX_START: begin
                if (w_expire) begin
                    if (!w_rx) begin
                        w_state_nxt   = UART_RX_DATA;
                        w_cnt_nxt     = FULL_RELOAD;
                        w_bit_idx_nxt = 3'd0;
                    end else begin
                        w_state_nxt = UART_RX_IDLE;
                    end
                end
            end
            UART_RX_DATA: begin
                if (w_expire) begin
                    w_shift_nxt   = {w_rx, r_shift[7:1]};
                    w_cnt_nxt     = FULL_RELOAD;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = UART_RX_PARITY;
`else
                        w_state_nxt = UART_RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            UART_RX_PARITY: begin
                if (w_expire) begin
                    w_par_err_nxt = ^{r_shift, w_rx};
                    w_cnt_nxt     = FULL_RELOAD;
                    w_state_nxt   = UART_RX_STOP;
                end
            end
`endif
            UART_RX_STOP: begin
                if (r_stop_wait) begin
                    // Hold here through a break so a low line cannot retrigger.
                    if (w_rx) begin
                        w_stop_wait_nxt = 1'b0;
                        w_state_nxt     = UART_RX_IDLE;
                    end
                end else if (w_expire) begin
                    if (w_rx) begin
                        w_parity_error_nxt = w_par_bad;
                        w_byte_valid_nxt   = !w_par_bad;
                        w_state_nxt        = UART_RX_IDLE;
                    end else begin
                        w_frame_error_nxt  = 1'b1;
                        w_parity_error_nxt = w_par_bad;
                        w_stop_wait_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = UART_RX_IDLE;
            end
        endcase
    end

    assign byte_valid   = r_byte_valid;
    assign byte_data    = r_shift;
    assign frame_error  = r_frame_error;
    assign parity_error = r_parity_error;

endmodule

// File: rtl/uart_rx_io.sv
// rtl/uart_rx_io.sv - memory-mapped UART receiver: FIFO, sticky flags, I/O decode (parity via UART_RX_PARITY_EN)
module uart_rx_io
    import uart_rx_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h18,
    parameter int          BAUD_DIVIDE  = 50000000 / 115200,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    input  logic        io_read_en,
    input  logic        io_write_en,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    logic          w_byte_valid;
    logic [7:0]    w_byte_data;
    logic          w_frame_error;
    logic          w_parity_error;

    logic [7:0]    r_mem [0:FIFO_DEPTH-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overrun;
    logic          r_frame_err;
    logic          r_parity_err;
    logic [31:0]   r_read_data;

    logic          w_status_sel;
    logic          w_data_sel;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_overrun_set;
    logic [3:1]    w_clear;
    logic [31:0]   w_status;
    logic          w_unused;

    uart_rx_deserializer #(
        .BAUD_DIVIDE (BAUD_DIVIDE)
    ) u_deser (
        .clk          (clk),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .byte_valid   (w_byte_valid),
        .byte_data    (w_byte_data),
        .frame_error  (w_frame_error),
        .parity_error (w_parity_error)
    );

    assign w_status_sel  = (io_address == BASE_ADDRESS + UART_RX_STATUS_OFFSET);
    assign w_data_sel    = (io_address == BASE_ADDRESS + UART_RX_DATA_OFFSET);
    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == FULL_COUNT);
    assign w_pop         = io_read_en && w_data_sel && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push        = w_byte_valid && (!w_full || w_pop);
    assign w_overrun_set = w_byte_valid && w_full && !w_pop;
    assign w_clear       = (io_write_en && w_status_sel) ? io_write_data[3:1] : 3'b000;
    assign w_status      = uart_rx_status_word(!w_empty, r_overrun, r_frame_err, r_parity_err);
    assign w_unused      = &{1'b0, io_write_data[31:4], io_write_data[0]};

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_byte_data;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags: write-1-to-clear, a same-cycle set takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_clear[UART_RX_STAT_OVERRUN]) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_error) begin
                r_frame_err <= 1'b1;
            end else if (w_clear[UART_RX_STAT_FRAME_ERR]) begin
                r_frame_err <= 1'b0;
            end
            if (w_parity_error) begin
                r_parity_err <= 1'b1;
            end else if (w_clear[UART_RX_STAT_PARITY_ERR]) begin
                r_parity_err <= 1'b0;
            end
        end
    end

    // Registered read response; holds between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_data <= 32'd0;
        end else if (io_read_en) begin
            if (w_status_sel) begin
                r_read_data <= w_status;
            end else if (w_data_sel) begin
                r_read_data <= w_empty ? 32'd0 : {24'd0, r_mem[r_rd_ptr]};
            end else begin
                r_read_data <= 32'd0;
            end
        end
    end

    assign io_read_data = r_read_data;

endmodule
